// File: rtl/wb_cpu_arbiter.sv
// Two-master Wishbone arbiter in front of the data (m0) and instruction (m1) CMUs.
// Ownership lasts a whole cyc; round-robin on ties; a watchdog force-completes hung strobes.
module wb_cpu_arbiter #(
   parameter int TIMEOUT  = 256,
   parameter int TO_WIDTH = 9
) (
   input  logic        wbm_clk_i,
   input  logic        rst,

   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic [29:0] m0_addr_i,
   input  logic [2:0]  m0_cti_i,
   input  logic [1:0]  m0_bte_i,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_data_i,
   output logic [31:0] m0_data_o,
   output logic        m0_ack_o,

   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic [29:0] m1_addr_i,
   input  logic [2:0]  m1_cti_i,
   input  logic [1:0]  m1_bte_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_data_i,
   output logic [31:0] m1_data_o,
   output logic        m1_ack_o,

   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic [29:0] s_addr_o,
   output logic [2:0]  s_cti_o,
   output logic [1:0]  s_bte_o,
   output logic [3:0]  s_sel_o,
   output logic        s_we_o,
   output logic [31:0] s_data_o,
   input  logic [31:0] s_data_i,
   input  logic        s_ack_i,

   output logic [1:0]  grant,
   output logic        bus_timeout
);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

   localparam bit WD_EN = (TIMEOUT > 0);
   localparam logic [TO_WIDTH-1:0] WD_LAST = TO_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t              state;
   logic                last;
   logic [TO_WIDTH-1:0] wd_cnt;

   logic own0, own1, own_cyc, own_stb, wd_fire;

   assign own0    = (state == OWN0);
   assign own1    = (state == OWN1);
   assign own_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
   assign own_stb = (own0 & m0_cyc_i & m0_stb_i) | (own1 & m1_cyc_i & m1_stb_i);
   assign wd_fire = WD_EN && own_stb && !s_ack_i && (wd_cnt == WD_LAST);

   // On release the other master is checked first, so a CMU gap cycle can hand over the bus.
   always_ff @(posedge wbm_clk_i) begin
      if (rst) begin
         state  <= IDLE;
         last   <= 1'b1;
         wd_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_cyc_i && m1_cyc_i) state <= last ? OWN0 : OWN1;
               else if (m0_cyc_i)        state <= OWN0;
               else if (m1_cyc_i)        state <= OWN1;
               else                      state <= IDLE;
            end
            OWN0: begin
               if (!m0_cyc_i) begin
                  last  <= 1'b0;
                  state <= m1_cyc_i ? OWN1 : IDLE;
               end
            end
            OWN1: begin
               if (!m1_cyc_i) begin
                  last  <= 1'b1;
                  state <= m0_cyc_i ? OWN0 : IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // own_cyc low covers IDLE and the release cycle of an owner change.
         if (!WD_EN || !own_cyc || s_ack_i || wd_fire)
            wd_cnt <= '0;
         else if (own_stb)
            wd_cnt <= wd_cnt + TO_WIDTH'(1);
      end
   end

   always_comb begin
      s_addr_o = '0;
      s_cti_o  = '0;
      s_bte_o  = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_data_o = '0;
      if (own0) begin
         s_addr_o = m0_addr_i;
         s_cti_o  = m0_cti_i;
         s_bte_o  = m0_bte_i;
         s_sel_o  = m0_sel_i;
         s_we_o   = m0_we_i;
         s_data_o = m0_data_i;
      end else if (own1) begin
         s_addr_o = m1_addr_i;
         s_cti_o  = m1_cti_i;
         s_bte_o  = m1_bte_i;
         s_sel_o  = m1_sel_i;
         s_we_o   = m1_we_i;
         s_data_o = m1_data_i;
      end
   end

   // A forced completion withdraws the strobe and returns zero data to the owner.
   assign s_cyc_o     = own_cyc;
   assign s_stb_o     = own_stb & ~wd_fire;
   assign m0_ack_o    = own0 & (wd_fire | (own_stb & s_ack_i));
   assign m1_ack_o    = own1 & (wd_fire | (own_stb & s_ack_i));
   assign m0_data_o   = (own0 && !wd_fire) ? s_data_i : 32'd0;
   assign m1_data_o   = (own1 && !wd_fire) ? s_data_i : 32'd0;
   assign grant       = {own1, own0};
   assign bus_timeout = wd_fire;

endmodule
